// File: rtl/ins_assemble.sv
// ============================================================================
// Module      : ins_assemble
// Description : Collects 1-3 byte 8051 instructions from the program-memory
//               byte stream and presents each one as a single held word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ins_assemble (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   input  logic [15:0] byte_addr,
   output logic        byte_ready,
   input  logic        flush,
   output logic        ins_valid,
   input  logic        ins_ready,
   output logic [7:0]  opcode,
   output logic [7:0]  operand1,
   output logic [7:0]  operand2,
   output logic [1:0]  ins_len,
   output logic [15:0] ins_pc,
   output logic        illegal
);

   localparam logic [7:0] c_ILLEGAL_OPC = 8'hA5;

   typedef enum logic [1:0] {
      OPC  = 2'd0,
      OPR1 = 2'd1,
      OPR2 = 2'd2,
      HOLD = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic        w_accept;
   logic [1:0]  w_len;
   logic [7:0]  r_opcode;
   logic [7:0]  r_operand1;
   logic [7:0]  r_operand2;
   logic [1:0]  r_len;
   logic [15:0] r_pc;
   logic        r_illegal;

   // 8051 instruction length from the opcode byte; anything unlisted is 1.
   function automatic logic [1:0] decode_len(input logic [7:0] op);
      logic [1:0] len;
      len = 2'd1;
      if (op[3:0] == 4'h1) len = 2'd2;
      case (op)
         8'h40, 8'h50, 8'h60, 8'h70, 8'h80,
         8'h24, 8'h34, 8'h44, 8'h54, 8'h64, 8'h74, 8'h94,
         8'h05, 8'h15, 8'h25, 8'h35, 8'h45, 8'h55, 8'h65, 8'h95,
         8'hC5, 8'hE5, 8'hF5,
         8'h42, 8'h52, 8'h62, 8'h72, 8'h82, 8'h92, 8'hA2, 8'hB2,
         8'hC2, 8'hD2,
         8'hA0, 8'hB0, 8'hC0, 8'hD0: len = 2'd2;
         default: ;
      endcase
      if ((op >= 8'h76 && op <= 8'h7F) || (op >= 8'h86 && op <= 8'h8F) ||
          (op >= 8'hA6 && op <= 8'hAF) || (op >= 8'hD8 && op <= 8'hDF))
         len = 2'd2;
      case (op)
         8'h02, 8'h12, 8'h10, 8'h20, 8'h30, 8'h43, 8'h53, 8'h63,
         8'h75, 8'h85, 8'h90, 8'hD5: len = 2'd3;
         default: ;
      endcase
      if (op >= 8'hB4 && op <= 8'hBF) len = 2'd3;
      return len;
   endfunction

   assign byte_ready = (r_state != HOLD);
   assign ins_valid  = (r_state == HOLD);
   assign w_accept   = byte_valid && byte_ready && !flush;
   assign w_len      = decode_len(byte_data);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= OPC;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      if (flush) begin
         w_next = OPC;
      end else begin
         case (r_state)
            OPC:  if (w_accept) w_next = (w_len == 2'd1) ? HOLD : OPR1;
            OPR1: if (w_accept) w_next = (r_len == 2'd2) ? HOLD : OPR2;
            OPR2: if (w_accept) w_next = HOLD;
            HOLD: if (ins_ready) w_next = OPC;
            default: w_next = OPC;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_opcode   <= 8'h00;
         r_operand1 <= 8'h00;
         r_operand2 <= 8'h00;
         r_len      <= 2'd1;
         r_pc       <= 16'h0000;
         r_illegal  <= 1'b0;
      end else if (w_accept) begin
         case (r_state)
            OPC: begin
               r_opcode   <= byte_data;
               r_pc       <= byte_addr;
               r_operand1 <= 8'h00;
               r_operand2 <= 8'h00;
               r_len      <= w_len;
               r_illegal  <= (byte_data == c_ILLEGAL_OPC);
            end
            OPR1:    r_operand1 <= byte_data;
            OPR2:    r_operand2 <= byte_data;
            default: ;
         endcase
      end
   end

   assign opcode   = r_opcode;
   assign operand1 = r_operand1;
   assign operand2 = r_operand2;
   assign ins_len  = r_len;
   assign ins_pc   = r_pc;
   assign illegal  = r_illegal;

endmodule

`default_nettype wire

// File: tb/tb_ins_assemble.sv
// ============================================================================
// Module      : tb_ins_assemble
// Description : Scoreboard bench for ins_assemble using directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ins_assemble;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        byte_valid = 1'b0;
   logic [7:0]  byte_data = 8'h00;
   logic [15:0] byte_addr = 16'h0000;
   logic        byte_ready;
   logic        flush = 1'b0;
   logic        ins_valid;
   logic        ins_ready = 1'b1;
   logic [7:0]  opcode, operand1, operand2;
   logic [1:0]  ins_len;
   logic [15:0] ins_pc;
   logic        illegal;

   int tests  = 0;
   int failed = 0;

   typedef struct packed {
      logic [7:0]  op;
      logic [7:0]  o1;
      logic [7:0]  o2;
      logic [1:0]  len;
      logic [15:0] pc;
      logic        ill;
   } exp_t;

   exp_t sb[$];

   ins_assemble dut (
      .clk(clk), .rst_n(rst_n), .byte_valid(byte_valid), .byte_data(byte_data),
      .byte_addr(byte_addr), .byte_ready(byte_ready), .flush(flush),
      .ins_valid(ins_valid), .ins_ready(ins_ready), .opcode(opcode),
      .operand1(operand1), .operand2(operand2), .ins_len(ins_len),
      .ins_pc(ins_pc), .illegal(illegal)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every consumed instruction must match the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && ins_valid && ins_ready) begin
            if (sb.size() == 0) begin
               check("unexpected_ins", {24'h0, opcode}, 32'hFFFF_FFFF);
            end else begin
               e = sb.pop_front();
               check("opcode",   {24'h0, opcode},   {24'h0, e.op});
               check("operand1", {24'h0, operand1}, {24'h0, e.o1});
               check("operand2", {24'h0, operand2}, {24'h0, e.o2});
               check("ins_len",  {30'h0, ins_len},  {30'h0, e.len});
               check("ins_pc",   {16'h0, ins_pc},   {16'h0, e.pc});
               check("illegal",  {31'h0, illegal},  {31'h0, e.ill});
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] d, input logic [15:0] a);
      int n = 0;
      byte_valid = 1'b1;
      byte_data  = d;
      byte_addr  = a;
      while (!byte_ready && n < 50) begin
         tick(1);
         n++;
      end
      if (!byte_ready) check("byte_ready_timeout", 32'h0, 32'h1);
      tick(1);
      byte_valid = 1'b0;
   endtask

   task automatic push(input logic [7:0] op, input logic [7:0] o1, input logic [7:0] o2,
                       input logic [1:0] len, input logic [15:0] pc, input logic ill);
      exp_t e;
      e = '{op: op, o1: o1, o2: o2, len: len, pc: pc, ill: ill};
      sb.push_back(e);
   endtask

   // Opcode / hand-decoded length pairs for decoder coverage.
   logic [7:0] dec_op  [16] = '{8'h11, 8'hB5, 8'hD8, 8'h85, 8'h86, 8'hA6, 8'hC5, 8'hD5,
                                8'h7F, 8'h76, 8'h00, 8'h23, 8'hF5, 8'hB2, 8'h43, 8'hE1};
   logic [1:0] dec_len [16] = '{2'd2, 2'd3, 2'd2, 2'd3, 2'd2, 2'd2, 2'd2, 2'd3,
                                2'd2, 2'd2, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd2};

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0]  o1, o2;
      logic [15:0] pc;

      #12;
      check("rst_ins_valid", {31'h0, ins_valid}, 32'h0);
      check("rst_opcode",    {24'h0, opcode},    32'h0);
      check("rst_len",       {30'h0, ins_len},   32'h1);
      check("rst_pc",        {16'h0, ins_pc},    32'h0);
      check("rst_byte_ready",{31'h0, byte_ready},32'h1);
      rst_n = 1'b1;
      tick(2);

      // 1-byte instruction, latency and return to OPC
      push(8'hE4, 8'h00, 8'h00, 2'd1, 16'hA845, 1'b0);
      send_byte(8'hE4, 16'hA845);
      check("t1_valid", {31'h0, ins_valid}, 32'h1);
      check("t1_ready_hold", {31'h0, byte_ready}, 32'h0);
      tick(1);
      check("t1_back_opc", {31'h0, byte_ready}, 32'h1);
      check("t1_valid_low", {31'h0, ins_valid}, 32'h0);

      // 3-byte with idle gaps between bytes
      push(8'h02, 8'h12, 8'h34, 2'd3, 16'h0100, 1'b0);
      send_byte(8'h02, 16'h0100);
      tick(2);
      check("t2_no_valid_gap", {31'h0, ins_valid}, 32'h0);
      send_byte(8'h12, 16'h0101);
      tick(1);
      send_byte(8'h34, 16'h0102);
      check("t2_valid", {31'h0, ins_valid}, 32'h1);
      tick(1);

      // Backpressure: held stable, junk byte offered in HOLD and exit cycle
      ins_ready = 1'b0;
      push(8'h74, 8'h55, 8'h00, 2'd2, 16'h0200, 1'b0);
      send_byte(8'h74, 16'h0200);
      send_byte(8'h55, 16'h0201);
      byte_valid = 1'b1;
      byte_data  = 8'hFF;
      byte_addr  = 16'hDEAD;
      for (int i = 0; i < 5; i++) begin
         check("t3_valid",      {31'h0, ins_valid},  32'h1);
         check("t3_byte_ready", {31'h0, byte_ready}, 32'h0);
         check("t3_opcode",     {24'h0, opcode},     32'h74);
         check("t3_operand1",   {24'h0, operand1},   32'h55);
         tick(1);
      end
      ins_ready = 1'b1;
      tick(1);
      byte_valid = 1'b0;
      check("t3_released", {31'h0, ins_valid}, 32'h0);
      tick(2);
      check("t3_no_backtoback", {31'h0, ins_valid}, 32'h0);

      // Flush in OPR2 with a byte offered the same cycle
      send_byte(8'h90, 16'h0300);
      send_byte(8'hAB, 16'h0301);
      byte_valid = 1'b1;
      byte_data  = 8'hCD;
      byte_addr  = 16'h0302;
      flush      = 1'b1;
      tick(1);
      flush      = 1'b0;
      byte_valid = 1'b0;
      check("t4_valid_low", {31'h0, ins_valid},  32'h0);
      check("t4_opcode_kept", {24'h0, opcode},   32'h90);
      check("t4_op1_kept",  {24'h0, operand1},   32'hAB);
      check("t4_op2_kept",  {24'h0, operand2},   32'h00);
      tick(2);
      check("t4_still_low", {31'h0, ins_valid},  32'h0);
      push(8'h00, 8'h00, 8'h00, 2'd1, 16'h0310, 1'b0);
      send_byte(8'h00, 16'h0310);
      tick(1);

      // Flush while holding an instruction
      ins_ready = 1'b0;
      send_byte(8'h80, 16'h0400);
      send_byte(8'h12, 16'h0401);
      check("t4b_hold", {31'h0, ins_valid}, 32'h1);
      flush = 1'b1;
      tick(1);
      flush = 1'b0;
      check("t4b_flushed", {31'h0, ins_valid}, 32'h0);
      ins_ready = 1'b1;

      // Illegal opcode
      push(8'hA5, 8'h00, 8'h00, 2'd1, 16'h0500, 1'b1);
      send_byte(8'hA5, 16'h0500);
      tick(1);

      // Decoder table
      for (int i = 0; i < 16; i++) begin
         pc = 16'h1000 + 16'(i * 4);
         o1 = (dec_len[i] >= 2'd2) ? 8'(8'h30 + i) : 8'h00;
         o2 = (dec_len[i] == 2'd3) ? 8'(8'h60 + i) : 8'h00;
         push(dec_op[i], o1, o2, dec_len[i], pc, 1'b0);
         send_byte(dec_op[i], pc);
         if (dec_len[i] >= 2'd2) send_byte(o1, pc + 16'd1);
         if (dec_len[i] == 2'd3) send_byte(o2, pc + 16'd2);
         check("dec_valid", {31'h0, ins_valid}, 32'h1);
         tick(1);
      end

      // Asynchronous reset in the middle of 75's operand phase
      send_byte(8'h75, 16'h0600);
      #2;
      rst_n = 1'b0;
      #1;
      check("t5_rst_valid",  {31'h0, ins_valid}, 32'h0);
      check("t5_rst_opcode", {24'h0, opcode},    32'h0);
      check("t5_rst_len",    {30'h0, ins_len},   32'h1);
      check("t5_rst_pc",     {16'h0, ins_pc},    32'h0);
      check("t5_rst_ill",    {31'h0, illegal},   32'h0);
      tick(2);
      #2;
      rst_n = 1'b1;
      tick(1);
      push(8'h33, 8'h00, 8'h00, 2'd1, 16'h0700, 1'b0);
      send_byte(8'h33, 16'h0700);
      check("t5_first_is_opc", {31'h0, ins_valid}, 32'h1);
      tick(3);

      check("sb_empty", 32'(sb.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

`default_nettype wire
